// File: rtl/traffic_ctrl.sv
// Four-way intersection controller with a pedestrian walk phase.
// A prescaler divides clock into timing ticks; a phase FSM steps the
// lamps through NS green/yellow, all-red, EW green/yellow, all-red, and
// inserts a WALK phase after either all-red when a request is waiting.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-low
//   en          1 = run, 0 = freeze prescaler and FSM
//   ped_req     pedestrian button (level or pulse)
//   ns_light    north-south lamps {red,yellow,green}, one-hot
//   ew_light    east-west lamps {red,yellow,green}, one-hot
//   walk        pedestrian walk lamp
//   ped_pending a latched pedestrian request is waiting
//   tick        one-cycle timing tick strobe
//   phase       current FSM state code
//
// state | meaning
// NS_G  | north-south green, east-west red
// NS_Y  | north-south yellow, east-west red
// RED_A | all-red clearance after NS traffic
// EW_G  | east-west green, north-south red
// EW_Y  | east-west yellow, north-south red
// RED_B | all-red clearance after EW traffic
// WALK  | all-red with walk lamp lit
module traffic_ctrl #(
  parameter int TICK_DIV = 25000000,
  parameter int GREEN_T  = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic       tick,
  output logic [2:0] phase
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5,
    WALK  = 3'd6
  } state_t;

  logic [PW-1:0] pre;
  state_t        state, state_nxt;
  logic [7:0]    timer, timer_nxt;
  logic          dir_b, dir_nxt;
  logic          wrap;
  logic          pend_nxt;
  logic [2:0]    ns_nxt, ew_nxt;
  logic          walk_nxt;

  function automatic logic [7:0] dur_m1(input state_t s);
    case (s)
      NS_G, EW_G: dur_m1 = 8'(GREEN_T - 1);
      NS_Y, EW_Y: dur_m1 = 8'(YELLOW_T - 1);
      WALK:       dur_m1 = 8'(WALK_T - 1);
      default:    dur_m1 = 8'(ALLRED_T - 1);
    endcase
  endfunction

  // The FSM advances on the same edge that the prescaler wraps, so the
  // tick strobe and the resulting state change appear together.
  assign wrap = en && (pre == PRE_MAX);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    dir_nxt   = dir_b;
    case (state)
      NS_G, NS_Y, RED_A, EW_G, EW_Y, RED_B, WALK: begin
        if (wrap) begin
          if (timer != 8'd0) begin
            timer_nxt = timer - 8'd1;
          end else begin
            case (state)
              NS_G:  state_nxt = NS_Y;
              NS_Y:  state_nxt = RED_A;
              EW_G:  state_nxt = EW_Y;
              EW_Y:  state_nxt = RED_B;
              RED_A: begin
                if (ped_pending || ped_req) begin
                  state_nxt = WALK;
                  dir_nxt   = 1'b0;
                end else begin
                  state_nxt = EW_G;
                end
              end
              RED_B: begin
                if (ped_pending || ped_req) begin
                  state_nxt = WALK;
                  dir_nxt   = 1'b1;
                end else begin
                  state_nxt = NS_G;
                end
              end
              WALK:    state_nxt = dir_b ? NS_G : EW_G;
              default: state_nxt = NS_G;
            endcase
            timer_nxt = dur_m1(state_nxt);
          end
        end
      end
      default: begin
        // Illegal code: recover regardless of en.
        state_nxt = NS_G;
        timer_nxt = dur_m1(NS_G);
        dir_nxt   = 1'b0;
      end
    endcase
  end

  // Clearing on WALK entry takes priority over a simultaneous request.
  always_comb begin
    pend_nxt = ped_pending;
    if ((state_nxt == WALK) && (state != WALK))
      pend_nxt = 1'b0;
    else if (ped_req && (state != WALK))
      pend_nxt = 1'b1;
  end

  always_comb begin
    ns_nxt   = 3'b100;
    ew_nxt   = 3'b100;
    walk_nxt = 1'b0;
    case (state_nxt)
      NS_G:    ns_nxt = 3'b001;
      NS_Y:    ns_nxt = 3'b010;
      EW_G:    ew_nxt = 3'b001;
      EW_Y:    ew_nxt = 3'b010;
      WALK:    walk_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre         <= '0;
      tick        <= 1'b0;
      state       <= NS_G;
      timer       <= 8'(GREEN_T - 1);
      dir_b       <= 1'b0;
      phase       <= 3'd0;
      ns_light    <= 3'b001;
      ew_light    <= 3'b100;
      walk        <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      if (en)
        pre <= (pre == PRE_MAX) ? '0 : pre + PW'(1);
      tick        <= wrap;
      state       <= state_nxt;
      timer       <= timer_nxt;
      dir_b       <= dir_nxt;
      phase       <= state_nxt;
      ns_light    <= ns_nxt;
      ew_light    <= ew_nxt;
      walk        <= walk_nxt;
      ped_pending <= pend_nxt;
    end
  end

endmodule

// File: doc/traffic_ctrl.md
TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 The module SHALL provide these parameters (name, default, meaning):
- TICK_DIV, 25000000, clock cycles per timing tick.
- GREEN_T, 10, green duration in ticks.
- YELLOW_T, 3, yellow duration in ticks.
- ALLRED_T, 1, all-red clearance duration in ticks.
- WALK_T, 5, pedestrian walk duration in ticks.

REQ-002 The module SHALL provide these ports (name, direction, width, meaning):
- clock, input, 1, system clock; all state changes on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- en, input, 1, 1 = run; 0 = freeze the prescaler and the FSM.
- ped_req, input, 1, pedestrian button; level or pulse, sampled every clock.
- ns_light, output, 3, north-south lamps {red,yellow,green}, one-hot.
- ew_light, output, 3, east-west lamps {red,yellow,green}, one-hot.
- walk, output, 1, pedestrian walk lamp.
- ped_pending, output, 1, a latched pedestrian request is waiting.
- tick, output, 1, one-cycle timing tick strobe.
- phase, output, 3, current FSM state encoding.

REQ-003 Clock is clock; reset is reset, asynchronous, active-low.

REQ-004 All outputs SHALL be registered.

Function
REQ-005 Prescaler:
- Width is clog2(TICK_DIV) bits.
- Counts 0..TICK_DIV-1 while en=1, then wraps to 0.
- tick=1 for exactly the cycle in which the count wraps; tick=0 otherwise.
- While en=0 the prescaler holds its value and tick=0.

REQ-006 FSM states and phase encoding: NS_G=0, NS_Y=1, RED_A=2, EW_G=3, EW_Y=4, RED_B=5, WALK=6. Code 7 is illegal and SHALL recover to NS_G on the next clock.

REQ-007 Phase timer:
- 8-bit down-counter.
- Loaded with (duration-1) of the state being entered.
- Decrements on each tick.
- The state exits on a tick that occurs while the timer is 0, so each state lasts exactly its duration in ticks.

REQ-008 Transitions on the exiting tick:
- NS_G->NS_Y, NS_Y->RED_A, EW_G->EW_Y, EW_Y->RED_B.
- RED_A->WALK if (ped_pending|ped_req), else EW_G.
- RED_B->WALK if (ped_pending|ped_req), else NS_G.
- WALK->EW_G if it was entered from RED_A; WALK->NS_G if entered from RED_B. A 1-bit direction flag records the entry point.

REQ-009 Lamps per state:
- NS_G: ns_light=001, ew_light=100.
- NS_Y: ns_light=010, ew_light=100.
- EW_G: ns_light=100, ew_light=001.
- EW_Y: ns_light=100, ew_light=010.
- RED_A, RED_B, WALK: ns_light=100, ew_light=100.
- walk=1 only in WALK.
- No two green lamps and no green-plus-walk SHALL ever be asserted together.

REQ-010 ped_pending:
- Set on any cycle with ped_req=1 outside WALK, including while en=0.
- Cleared in the cycle WALK is entered. Clear wins over a simultaneous ped_req.
- ped_req while in WALK is ignored.

REQ-011 While en=0, the state, phase timer, lamps and walk SHALL hold their values. Only ped_pending may change.

REQ-012 Duration parameters SHALL be in the range 1..255. TICK_DIV SHALL be >= 2.

Reset
REQ-013 Asserting reset SHALL immediately, without waiting for a clock edge, produce:
- prescaler=0, phase=NS_G, timer=GREEN_T-1, direction flag=RED_A path.
- ns_light=001, ew_light=100, walk=0, ped_pending=0, tick=0.

REQ-014 Reset asserted mid-phase SHALL abandon that phase. After release, operation resumes from NS_G with a full GREEN_T.

Verification
Benches use TICK_DIV=4 and the default durations.

REQ-015 Free run: release reset, en=1, no ped_req -> phase sequence 0,1,2,3,4,5,0 lasting 10,3,1,10,3,1 ticks; tick period 4 cycles; first tick 4 cycles after reset release.

REQ-016 Pedestrian: 1-cycle ped_req during NS_G -> ped_pending=1 on the next cycle, then:
- NS_Y, RED_A, then WALK for 5 ticks with walk=1, ns_light=100, ew_light=100;
- ped_pending=0 on WALK entry;
- then EW_G.

REQ-017 Boundary: ped_req asserted in exactly the RED_B exiting-tick cycle -> next state WALK, ped_pending=0; after WALK the state is NS_G. A second ped_req during WALK leaves ped_pending=0.

REQ-018 Freeze: en=0 for 50 cycles mid-EW_G, with a ped_req pulse during the freeze -> phase, timer, lamps unchanged and no tick; ped_pending=1. After en=1, the remaining EW_G ticks complete, and RED_B leads to WALK.

REQ-019 Async reset: reset=0 mid-EW_Y, between clock edges -> ns_light=001, ew_light=100, phase=0, ped_pending=0 before the next edge; after release, a full 10-tick NS_G.

REQ-020 Safety: across a 10,000-cycle run with random ped_req/en -> the green/green and green/walk exclusion checks of REQ-009 never fail, and phase is never 7.
